// File: rtl/button_select_pkg.sv
// Shared types and width helpers for the front-panel button select encoder.
//   state_e    : debouncer state (SETTLE while counting, HELD once a code is committed)
//   clog2_min1 : ceil(log2(n)), clamped to at least 1 so one-entry groups still get a bit
package button_select_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        HELD   = 1'b1
    } state_e;

    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/code_debouncer.sv
// Debounces an encoded button code. A code must be sampled identically on
// DEBOUNCE+1 consecutive edges before it is committed, and it commits once.
// A different code is needed before the same code can commit again.
//   clk_48  : clock
//   reset_n : synchronous active-low reset
//   buttons : synchronised button code
//   commit  : high during the cycle whose closing edge commits the code
//   code    : the code being committed (the candidate register)
module code_debouncer
    import button_select_pkg::*;
#(
    parameter int CODE_W   = 4,
    parameter int DEBOUNCE = 480
) (
    input  logic              clk_48,
    input  logic              reset_n,
    input  logic [CODE_W-1:0] buttons,
    output logic              commit,
    output logic [CODE_W-1:0] code
);

    localparam int CW = clog2_min1(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [CODE_W-1:0] cand;
    logic [CW-1:0]     cnt;
    state_e            state;

    // Reset leaves the state HELD with cand=0, so a 0 present at reset
    // release is treated as already committed and never overrides the
    // reset selections.
    always_ff @(posedge clk_48) begin
        if (!reset_n) begin
            cand  <= '0;
            cnt   <= '0;
            state <= HELD;
        end else if (buttons != cand) begin
            cand  <= buttons;
            cnt   <= '0;
            state <= SETTLE;
        end else if (state == SETTLE) begin
            if (cnt == LAST) begin
                state <= HELD;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Commit is taken by the consumer on the same edge that moves us to HELD,
    // so selections become visible right after edge DEBOUNCE.
    assign commit = (state == SETTLE) && (buttons == cand) && (cnt == LAST);
    assign code   = cand;

endmodule

// File: rtl/button_select_encoder.sv
// Front-panel button select encoder for the channel strip. Debounces the
// encoded button code and decodes each committed code into the EQ frequency,
// low-pass corner or high-pass corner selection. Codes 0..FREQ_N-1 select a
// frequency, the next LP_N codes a low-pass corner, the next HP_N codes a
// high-pass corner; anything above is ignored.
//   clk_48         : clock
//   reset_n        : synchronous active-low reset
//   buttons        : synchronised button code
//   lock           : discard commits while high (not replayed on release)
//   freqSelect     : registered frequency selection
//   lowpassSelect  : registered low-pass selection
//   highpassSelect : registered high-pass selection
//   freq_chg       : one-cycle pulse after freqSelect changes value
//   lp_chg         : one-cycle pulse after lowpassSelect changes value
//   hp_chg         : one-cycle pulse after highpassSelect changes value
module button_select_encoder
    import button_select_pkg::*;
#(
    parameter int CODE_W   = 4,
    parameter int FREQ_N   = 8,
    parameter int LP_N     = 4,
    parameter int HP_N     = 4,
    parameter int DEBOUNCE = 480,
    parameter int FREQ_RST = 4,
    parameter int LP_RST   = 1,
    parameter int HP_RST   = 3
) (
    input  logic                          clk_48,
    input  logic                          reset_n,
    input  logic [CODE_W-1:0]             buttons,
    input  logic                          lock,
    output logic [clog2_min1(FREQ_N)-1:0] freqSelect,
    output logic [clog2_min1(LP_N)-1:0]   lowpassSelect,
    output logic [clog2_min1(HP_N)-1:0]   highpassSelect,
    output logic                          freq_chg,
    output logic                          lp_chg,
    output logic                          hp_chg
);

    localparam int FW = clog2_min1(FREQ_N);
    localparam int LW = clog2_min1(LP_N);
    localparam int HW = clog2_min1(HP_N);

    localparam logic [31:0] LP_BASE = 32'(FREQ_N);
    localparam logic [31:0] HP_BASE = 32'(FREQ_N + LP_N);
    localparam logic [31:0] HP_END  = 32'(FREQ_N + LP_N + HP_N);

    logic              commit;
    logic [CODE_W-1:0] code;

    code_debouncer #(
        .CODE_W   (CODE_W),
        .DEBOUNCE (DEBOUNCE)
    ) u_debouncer (
        .clk_48  (clk_48),
        .reset_n (reset_n),
        .buttons (buttons),
        .commit  (commit),
        .code    (code)
    );

    logic [31:0]   code_ext;
    logic          take;
    logic          in_freq, in_lp, in_hp;
    logic [FW-1:0] freq_new;
    logic [LW-1:0] lp_new;
    logic [HW-1:0] hp_new;

    assign code_ext = 32'(code);
    assign take     = commit && !lock;

    // Range decode; offsets are truncated to each group's width.
    always_comb begin
        in_freq  = (code_ext < LP_BASE);
        in_lp    = (code_ext >= LP_BASE) && (code_ext < HP_BASE);
        in_hp    = (code_ext >= HP_BASE) && (code_ext < HP_END);
        freq_new = FW'(code_ext);
        lp_new   = LW'(code_ext - LP_BASE);
        hp_new   = HW'(code_ext - HP_BASE);
    end

    // Selections and strobes. Strobes default low so each lasts one cycle,
    // and only fire when the committed value differs from the held one.
    always_ff @(posedge clk_48) begin
        if (!reset_n) begin
            freqSelect     <= FW'(FREQ_RST);
            lowpassSelect  <= LW'(LP_RST);
            highpassSelect <= HW'(HP_RST);
            freq_chg       <= 1'b0;
            lp_chg         <= 1'b0;
            hp_chg         <= 1'b0;
        end else begin
            freq_chg <= 1'b0;
            lp_chg   <= 1'b0;
            hp_chg   <= 1'b0;
            if (take && in_freq) begin
                freqSelect <= freq_new;
                freq_chg   <= (freq_new != freqSelect);
            end
            if (take && in_lp) begin
                lowpassSelect <= lp_new;
                lp_chg        <= (lp_new != lowpassSelect);
            end
            if (take && in_hp) begin
                highpassSelect <= hp_new;
                hp_chg         <= (hp_new != highpassSelect);
            end
        end
    end

endmodule

// File: tb/tb_button_select_encoder.sv
// Bench for button_select_encoder with DEBOUNCE=8 and default code map:
// codes 0..7 frequency, 8..11 low-pass, 12..15 high-pass.
module tb_button_select_encoder;

    localparam int CODE_W   = 4;
    localparam int DEBOUNCE = 8;

    logic       clk_48  = 1'b0;
    logic       reset_n = 1'b0;
    logic       lock    = 1'b0;
    logic [3:0] buttons = 4'd0;
    logic [2:0] freqSelect;
    logic [1:0] lowpassSelect;
    logic [1:0] highpassSelect;
    logic       freq_chg, lp_chg, hp_chg;

    int n_pass  = 0;
    int n_total = 0;
    int f_cnt   = 0;
    int l_cnt   = 0;
    int h_cnt   = 0;

    always #5 clk_48 = ~clk_48;

    button_select_encoder #(
        .CODE_W   (CODE_W),
        .FREQ_N   (8),
        .LP_N     (4),
        .HP_N     (4),
        .DEBOUNCE (DEBOUNCE),
        .FREQ_RST (4),
        .LP_RST   (1),
        .HP_RST   (3)
    ) dut (
        .clk_48         (clk_48),
        .reset_n        (reset_n),
        .buttons        (buttons),
        .lock           (lock),
        .freqSelect     (freqSelect),
        .lowpassSelect  (lowpassSelect),
        .highpassSelect (highpassSelect),
        .freq_chg       (freq_chg),
        .lp_chg         (lp_chg),
        .hp_chg         (hp_chg)
    );

    typedef struct {
        logic [3:0] b;
        logic       lk;
        int         cyc;
        int         f, l, h;
        int         fc, lc, hc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock edge, then sample 1 time unit later and tally strobes.
    task automatic tick();
        @(posedge clk_48);
        #1;
        if (freq_chg) f_cnt++;
        if (lp_chg)   l_cnt++;
        if (hp_chg)   h_cnt++;
    endtask

    task automatic clear_cnt();
        f_cnt = 0;
        l_cnt = 0;
        h_cnt = 0;
    endtask

    task automatic check_sel(input string tag, input int f, input int l, input int h);
        check({tag, " freqSelect"},     int'(freqSelect),     f);
        check({tag, " lowpassSelect"},  int'(lowpassSelect),  l);
        check({tag, " highpassSelect"}, int'(highpassSelect), h);
    endtask

    task automatic check_strb(input string tag, input int fc, input int lc, input int hc);
        check({tag, " freq_chg pulses"}, f_cnt, fc);
        check({tag, " lp_chg pulses"},   l_cnt, lc);
        check({tag, " hp_chg pulses"},   h_cnt, hc);
    endtask

    initial begin
        // b, lock, cycles, freq, lp, hp, freq_chg/lp_chg/hp_chg pulse counts
        vecs.push_back('{4'd0,  1'b0, 2000, 4, 1, 3, 0, 0, 0}); // 0 at release never commits
        vecs.push_back('{4'd6,  1'b0,    9, 6, 1, 3, 1, 0, 0}); // exactly DEBOUNCE+1 samples
        vecs.push_back('{4'd0,  1'b0,   20, 0, 1, 3, 1, 0, 0}); // 0 after a different code commits
        vecs.push_back('{4'd6,  1'b0,    8, 0, 1, 3, 0, 0, 0}); // one sample short
        vecs.push_back('{4'd0,  1'b0,   20, 0, 1, 3, 0, 0, 0}); // equal re-commit, no strobe
        vecs.push_back('{4'd10, 1'b0,   12, 0, 2, 3, 0, 1, 0}); // low-pass group
        vecs.push_back('{4'd13, 1'b0,   12, 0, 2, 1, 0, 0, 1}); // high-pass group
        vecs.push_back('{4'd15, 1'b0,   12, 0, 2, 3, 0, 0, 1}); // top code of high-pass group
        vecs.push_back('{4'd7,  1'b0,   12, 7, 2, 3, 1, 0, 0}); // top code of frequency group
        vecs.push_back('{4'd8,  1'b0,   12, 7, 0, 3, 0, 1, 0}); // first low-pass code
        vecs.push_back('{4'd9,  1'b0,   12, 7, 1, 3, 0, 1, 0}); // lp back to 1
        vecs.push_back('{4'd5,  1'b1,   20, 7, 1, 3, 0, 0, 0}); // locked commit discarded
        vecs.push_back('{4'd5,  1'b0,   20, 7, 1, 3, 0, 0, 0}); // no replay on unlock

        // Reset state
        reset_n = 1'b0;
        buttons = 4'd0;
        clear_cnt();
        repeat (3) tick();
        check_sel("reset", 4, 1, 3);
        check_strb("reset", 0, 0, 0);
        reset_n = 1'b1;

        // Table
        for (int i = 0; i < vecs.size(); i++) begin
            buttons = vecs[i].b;
            lock    = vecs[i].lk;
            clear_cnt();
            repeat (vecs[i].cyc) tick();
            check_sel($sformatf("vec%0d", i), vecs[i].f, vecs[i].l, vecs[i].h);
            check_strb($sformatf("vec%0d", i), vecs[i].fc, vecs[i].lc, vecs[i].hc);
        end
        lock = 1'b0;

        // Commit timing: still old after edge DEBOUNCE-1, new after edge DEBOUNCE
        buttons = 4'd2;
        clear_cnt();
        repeat (DEBOUNCE) tick();
        check("timing before commit", int'(freqSelect), 7);
        tick();
        check("timing at commit", int'(freqSelect), 2);
        check("timing strobe level", int'(freq_chg), 1);
        tick();
        check("timing strobe drop", int'(freq_chg), 0);

        // Bounce 9/10 every 3 cycles, then hold 9 (lp already 1)
        clear_cnt();
        for (int i = 0; i < 50; i++) begin
            buttons = ((i / 3) % 2 == 0) ? 4'd9 : 4'd10;
            tick();
        end
        check_sel("bounce", 2, 1, 3);
        check_strb("bounce", 0, 0, 0);
        buttons = 4'd9;
        repeat (20) tick();
        check_sel("bounce hold", 2, 1, 3);
        check_strb("bounce hold", 0, 0, 0);

        // Reset midway through a debounce of 7
        buttons = 4'd7;
        clear_cnt();
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        buttons = 4'd0;
        check_sel("mid reset", 4, 1, 3);
        repeat (20) tick();
        check_sel("after reset", 4, 1, 3);
        check_strb("after reset", 0, 0, 0);
        buttons = 4'd7;
        repeat (DEBOUNCE + 1) tick();
        check_sel("reapply 7", 7, 1, 3);
        check_strb("reapply 7", 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/button_select_encoder.md
# button_select_encoder

Parametrised successor to the front-panel button encoder for the channel strip. Takes the encoded button code, debounces it over a programmable window, and decodes each accepted code into one of three selection registers: EQ frequency, low-pass corner and high-pass corner. It adds a lock input and one-cycle change strobes, and it sits between the panel input synchroniser and the filter-coefficient selection logic.

## Interface
Parameters:
- CODE_W, 4: width of the button code.
- FREQ_N, 8: number of frequency selections. Codes 0..FREQ_N-1 map to them.
- LP_N, 4: number of low-pass selections. They use the next LP_N codes.
- HP_N, 4: number of high-pass selections. They use the next HP_N codes.
- DEBOUNCE, 480: number of consecutive stable cycles required before commit. Must be at least 1.
- FREQ_RST, 4: reset value of freqSelect.
- LP_RST, 1: reset value of lowpassSelect.
- HP_RST, 3: reset value of highpassSelect.
- Legal configuration requires FREQ_N+LP_N+HP_N <= 2^CODE_W.
- Each reset value must be below its group's N.

Ports:
- clk_48, in, 1: the only clock.
- reset_n, in, 1: synchronous, active-low reset.
- buttons, in, CODE_W: encoded button code, already synchronised to clk_48.
- lock, in, 1: when 1, debounced codes are discarded and selections stay frozen.
- freqSelect, out, FW = max(1, clog2(FREQ_N)): registered frequency selection.
- lowpassSelect, out, LW = max(1, clog2(LP_N)): registered low-pass selection.
- highpassSelect, out, HW = max(1, clog2(HP_N)): registered high-pass selection.
- freq_chg, out, 1: one-cycle pulse when freqSelect changes value.
- lp_chg, out, 1: one-cycle pulse when lowpassSelect changes value.
- hp_chg, out, 1: one-cycle pulse when highpassSelect changes value.

## Operation
- Internal registers:
  - cand (CODE_W): the candidate code.
  - cnt (clog2(DEBOUNCE+1) bits): count of stable cycles.
  - state: one of SETTLE or HELD.
- Reset (reset_n=0 at an edge):
  - Selects load FREQ_RST, LP_RST and HP_RST.
  - All strobes are 0.
  - cand=0, cnt=0, state=HELD.
  - Consequence: a code of 0 present at reset release never commits and never overrides the reset values.
- Reset taken mid-debounce aborts the pending commit with no partial update.
- Any state, buttons != cand: cand <= buttons, cnt <= 0, state <= SETTLE. This restarts the window.
- SETTLE, buttons == cand, cnt < DEBOUNCE-1: cnt increments.
- SETTLE, buttons == cand, cnt == DEBOUNCE-1: commit cand, then state <= HELD.
- HELD, buttons == cand: no action. A held code commits exactly once. Re-selecting the same code requires a different code in between.
- Commit decode, with F=FREQ_N and L=LP_N:
  - cand < F: freqSelect <= cand.
  - F <= cand < F+L: lowpassSelect <= cand-F.
  - F+L <= cand < F+L+HP_N: highpassSelect <= cand-F-L.
  - Otherwise: no register changes.
- Each subtraction result is truncated to its group's width. Only one group is written per commit.
- Strobes:
  - A strobe is 1 for exactly the cycle after the commit edge, and only if that group's value actually changed.
  - Re-committing an equal value gives no strobe.
  - Out-of-range codes give no strobe.
- Lock:
  - If lock=1 at the commit edge, the commit is discarded: no register update, no strobe, state still goes to HELD.
  - Releasing lock does not replay the discarded code.

## Timing
- Let the new stable code first be sampled at edge 0.
- cand loads at edge 0. The commit happens at edge DEBOUNCE.
- Selects and strobe are visible after edge DEBOUNCE, i.e. DEBOUNCE+1 consecutive identical samples are required.
- A glitch of any length under DEBOUNCE+1 cycles produces no output change.
- Strobes are registered, with zero combinational paths from input to output.
- Throughput: at most one commit per DEBOUNCE+1 cycles.

## Structure
- Package button_select_pkg holds:
  - the state enum typedef (SETTLE, HELD);
  - width helper functions (clog2 clamped to at least 1).
- Sub-module code_debouncer, parametrised by CODE_W and DEBOUNCE:
  - owns cand, cnt and state;
  - outputs commit (1-cycle) and code.
- Top-level responsibilities:
  - range decode;
  - lock gating;
  - select registers;
  - change strobes.

## Test plan
- Reset, then hold buttons=0 for 2000 cycles -> freq/lp/hp stay 4/1/3 and no strobe ever fires.
- Use DEBOUNCE=8. Apply buttons=6 for 9 cycles -> freqSelect=6 after edge 8, freq_chg high for exactly 1 cycle. Apply buttons=6 for only 8 cycles, then 0 -> no change.
- Apply buttons=10 stable -> lowpassSelect=2, lp_chg pulses. Then apply 13 -> highpassSelect=1, hp_chg pulses, freqSelect unchanged.
- Bounce 9/10/9/10 every 3 cycles for 50 cycles, then hold 9 -> exactly one commit with lowpassSelect=1. No lp_chg fires, because the value equals the current one.
- Hold lock=1 while 5 debounces, then release lock with 5 still held -> freqSelect unchanged throughout.
- Assert reset_n=0 for 1 cycle midway through a debounce of 7 -> outputs are 4/1/3 and no commit of 7 occurs unless 7 is re-applied after a different code.
